// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: unified program/data memory, serial program load, FETCH/EXEC sequencer.
// Two cycles per instruction; Load overrides everything but reset; run=0 freezes execution in place.
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Load,
  input  logic              run,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] Instruction,
  output logic [DATA_W-1:0] Acc,
  output logic [DATA_W-1:0] Mem,
  output logic [ADDR_W-1:0] Program_counter,
  output logic              halted,
  output logic [ADDR_W:0]   load_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] mem_opnd;

  assign opcode   = ir_q[DATA_W-1 -: 3];
  assign operand  = ir_q[ADDR_W-1:0];
  assign mem_opnd = mem_q[operand];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    acc_d        = acc_q;
    ir_d         = ir_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count_q;
    mem_we       = 1'b0;
    mem_waddr    = load_ptr_q;
    mem_wdata    = data_in;

    if (Load) begin
      // Load pre-empts whatever was executing; the abandoned instruction has no side effects.
      state_d    = S_LOAD;
      mem_we     = 1'b1;
      load_ptr_d = load_ptr_q + 1'b1;
      if (state_q != S_LOAD) begin
        load_count_d = {{ADDR_W{1'b0}}, 1'b1};
      end else if (load_count_q != CNT_MAX) begin
        load_count_d = load_count_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run) begin
            state_d = S_FETCH;
            pc_d    = '0;
          end
        end
        S_LOAD: begin
          state_d    = S_FETCH;
          pc_d       = '0;
          load_ptr_d = '0;
          ir_d       = '0;
        end
        S_FETCH: begin
          if (run) begin
            ir_d    = mem_q[pc_q];
            pc_d    = pc_q + 1'b1;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (run) begin
            state_d = (opcode == OP_HLT) ? S_HALT : S_FETCH;
            unique case (opcode)
              OP_SKZ:  if (acc_q == '0) pc_d = pc_q + 1'b1;
              OP_ADD:  acc_d = acc_q + mem_opnd;
              OP_AND:  acc_d = acc_q & mem_opnd;
              OP_XOR:  acc_d = acc_q ^ mem_opnd;
              OP_LDA:  acc_d = mem_opnd;
              OP_STO: begin
                mem_we    = 1'b1;
                mem_waddr = operand;
                mem_wdata = acc_q;
              end
              OP_JMP:  pc_d = operand;
              default: ;
            endcase
          end
        end
        S_HALT: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      acc_q        <= '0;
      ir_q         <= '0;
      load_ptr_q   <= '0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      acc_q        <= acc_d;
      ir_q         <= ir_d;
      load_ptr_q   <= load_ptr_d;
      load_count_q <= load_count_d;
    end
  end

  // Memory contents survive reset; only the write of the reset cycle is suppressed.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign Instruction     = ir_q;
  assign Acc             = acc_q;
  assign Mem             = mem_opnd;
  assign Program_counter = pc_q;
  assign halted          = (state_q == S_HALT);
  assign load_count      = load_count_q;

endmodule
